led_breather: RTL and testbench
===============================

LED_BREATHER -- requirements
Module: led_breather

Interface
REQ-001 Parameter NCH, default 4: number of independent LED channels, 1..16.
REQ-002 Parameter PW, default 8: PWM counter and brightness level width in bits.
REQ-003 Parameter PRE_BITS, default 12: ramp-step prescaler width; one ramp step every 2^PRE_BITS PWM periods.
REQ-004 Parameter CW = max(1, clog2(NCH)), derived: channel-select width.
REQ-005 i_clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 i_reset  in  1  asynchronous, active-high reset.
REQ-007 i_wr  in  1  write strobe; one write per asserted cycle.
REQ-008 i_wr_ch  in  CW  target channel index.
REQ-009 i_wr_mode  in  2  channel mode: 00 OFF, 01 STATIC, 10 SAW, 11 TRI.
REQ-010 i_wr_level  in  PW  starting or static brightness level.
REQ-011 o_led  out  NCH  registered PWM output per channel.
REQ-012 o_frame  out  1  registered one-cycle pulse marking the start of each PWM period.

Function
REQ-013 pwm_cnt (PW bits) shall increment every cycle and wrap from 2^PW-1 to 0.
REQ-014 pre_cnt (PRE_BITS bits) shall increment when pwm_cnt==2^PW-1 and wrap to 0.
REQ-015 step shall be asserted in exactly the cycle where pwm_cnt and pre_cnt are both all-ones.
REQ-016 Each channel shall hold the registers mode[1:0], level[PW-1:0], dir (0 = up) and duty[PW-1:0].
REQ-017 On step, SAW channels: level <= level+1, wrapping from 2^PW-1 to 0.
REQ-018 On step, TRI channels with dir up: level+1.
REQ-019 On step, TRI channels with dir up and level==2^PW-1: level <= 2^PW-2 and dir <= down.
REQ-020 On step, TRI channels with dir down: level-1.
REQ-021 On step, TRI channels with dir down and level==0: level <= 1 and dir <= up.
REQ-022 OFF and STATIC channels shall ignore step.
REQ-023 Write with i_wr_ch < NCH shall load mode and level into that channel on the next edge and set dir to up.
REQ-024 Write with i_wr_ch >= NCH shall be ignored.
REQ-025 A write and a step in the same cycle shall apply the write to the addressed channel; other channels still step.
REQ-026 When pwm_cnt==2^PW-1, duty <= (mode==OFF ? 0 : level); duty shall not change at any other time.
REQ-027 A level change shall therefore never alter the PWM period in progress.
REQ-028 o_led[k] <= (pwm_cnt < duty[k]), giving one cycle latency from pwm_cnt.
REQ-029 duty 0 shall give a constant-low output; duty 2^PW-1 shall give (2^PW-1)/2^PW high time, since 100% duty is not required.
REQ-030 o_frame <= (pwm_cnt==0).

Reset
REQ-031 While i_reset is high, all registers shall clear immediately, regardless of clock.
REQ-032 Cleared values: pwm_cnt 0, pre_cnt 0, mode OFF, level 0, dir up, duty 0, o_led all 0, o_frame 0.
REQ-033 A write presented during reset shall be discarded.
REQ-034 After reset deasserts, the first o_frame pulse shall appear on the edge after pwm_cnt reaches 0, the cycle following the first clock edge.

Structure
REQ-035 Package led_breather_pkg shall hold the mode encodings (MODE_OFF, MODE_STATIC, MODE_SAW, MODE_TRI) and the dir constants.
REQ-036 Sub-module breather_channel shall hold one channel's mode, level, dir and duty registers, the step logic and the output comparator.
REQ-037 breather_channel shall be instantiated NCH times by a generate loop.
REQ-038 pwm_cnt, pre_cnt and o_frame shall live once in led_breather and be shared by all channels.

Verification (NCH=3, PW=4, PRE_BITS=1 unless stated otherwise; step every 32 cycles)
REQ-039 Reset: pulse i_reset mid-period while ch0 is STATIC 9 -> o_led=000 asynchronously; after release, o_led stays 000 until a write is made.
REQ-040 Static: write ch0 STATIC level 5 -> from the next period, o_led[0] is high exactly 5 of every 16 cycles, always the first 5 after o_frame+0.
REQ-041 Saw: write ch1 SAW level 14 -> the duty seen over successive 32-cycle steps is 14, 15, 0, 1.
REQ-042 Tri: write ch2 TRI level 14 -> duty sequence 14, 15, 14, 13, ..., 1, 0, 1, 2.
REQ-043 Mid-period write: ch0 at duty 2, write STATIC 10 at pwm_cnt=3 -> the current period stays high 2 cycles and the next period is high 10.
REQ-044 Collisions: a write to ch1 on the step cycle -> the written level holds and no increment is applied; a write with i_wr_ch=3 -> no channel changes state.

Source files
------------

// File: rtl/led_breather_pkg.sv
// ---------------------------------------------------------------------------
// led_breather_pkg
//   Shared encodings for the LED breather: channel mode values and the
//   triangle-ramp direction constants. Imported by led_breather and
//   breather_channel.
// ---------------------------------------------------------------------------
package led_breather_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,  // output forced low, level held
    MODE_STATIC = 2'b01,  // fixed brightness
    MODE_SAW    = 2'b10,  // level ramps up and wraps
    MODE_TRI    = 2'b11   // level ramps up then down, bouncing at the ends
  } mode_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Channel-select width: at least one bit even for a single channel.
  function automatic int ch_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/breather_channel.sv
// ---------------------------------------------------------------------------
// breather_channel
//   One LED channel: mode/level/dir/duty registers, the ramp-step logic and
//   the PWM comparator.
//
//   i_clk, i_reset   clock, asynchronous active-high reset
//   i_step           ramp-step strobe shared by all channels
//   i_period_end     high in the last cycle of a PWM period (duty reload)
//   i_pwm_cnt        shared PWM counter
//   i_wr             write addressed to this channel (already decoded)
//   i_wr_mode        mode to load
//   i_wr_level       level to load
//   o_led            registered PWM output
// ---------------------------------------------------------------------------
module breather_channel
  import led_breather_pkg::*;
#(
  parameter int PW = 8
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_step,
  input  logic          i_period_end,
  input  logic [PW-1:0] i_pwm_cnt,
  input  logic          i_wr,
  input  logic [1:0]    i_wr_mode,
  input  logic [PW-1:0] i_wr_level,
  output logic          o_led
);

  localparam logic [PW-1:0] LVL_MAX = '1;
  localparam logic [PW-1:0] LVL_ONE = PW'(1);

  mode_e         r_mode;
  logic [PW-1:0] r_level;
  logic          r_dir;
  logic [PW-1:0] r_duty;
  logic          r_led;

  logic [PW-1:0] w_level_nxt;
  logic          w_dir_nxt;

  // Ramp step. Only SAW and TRI move; OFF and STATIC hold their level.
  always_comb begin
    w_level_nxt = r_level;
    w_dir_nxt   = r_dir;
    if (i_step) begin
      case (r_mode)
        MODE_SAW: w_level_nxt = r_level + LVL_ONE;  // natural wrap at 2^PW
        MODE_TRI: begin
          if (r_dir == DIR_UP) begin
            if (r_level == LVL_MAX) begin
              // bounce off the top: the top value is shown for one step only
              w_level_nxt = LVL_MAX - LVL_ONE;
              w_dir_nxt   = DIR_DOWN;
            end else begin
              w_level_nxt = r_level + LVL_ONE;
            end
          end else begin
            if (r_level == '0) begin
              w_level_nxt = LVL_ONE;
              w_dir_nxt   = DIR_UP;
            end else begin
              w_level_nxt = r_level - LVL_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_mode  <= MODE_OFF;
      r_level <= '0;
      r_dir   <= DIR_UP;
      r_duty  <= '0;
      r_led   <= 1'b0;
    end else begin
      // A write wins over a coincident step on this channel.
      if (i_wr) begin
        r_mode  <= mode_e'(i_wr_mode);
        r_level <= i_wr_level;
        r_dir   <= DIR_UP;
      end else begin
        r_level <= w_level_nxt;
        r_dir   <= w_dir_nxt;
      end
      // Duty is only reloaded at the period boundary so a level change can
      // never glitch the period already being emitted. It takes the level
      // as it stands before this edge's write/step.
      if (i_period_end)
        r_duty <= (r_mode == MODE_OFF) ? '0 : r_level;
      r_led <= (i_pwm_cnt < r_duty);
    end
  end

  assign o_led = r_led;

endmodule

// File: rtl/led_breather.sv
// ---------------------------------------------------------------------------
// led_breather
//   Multi-channel LED PWM driver with per-channel breathing ramps. A shared
//   PW-bit PWM counter defines the period; a PRE_BITS prescaler counts
//   periods and fires one ramp step every 2^PRE_BITS periods.
//
//   i_clk        clock
//   i_reset      asynchronous active-high reset
//   i_wr         write strobe (one write per asserted cycle)
//   i_wr_ch      target channel; indices >= NCH are ignored
//   i_wr_mode    00 OFF, 01 STATIC, 10 SAW, 11 TRI
//   i_wr_level   start / static level
//   o_led        registered PWM output, one bit per channel
//   o_frame      registered pulse marking the first cycle of each period
// ---------------------------------------------------------------------------
module led_breather
  import led_breather_pkg::*;
#(
  parameter  int NCH      = 4,
  parameter  int PW       = 8,
  parameter  int PRE_BITS = 12,
  localparam int CW       = ch_width(NCH)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_wr,
  input  logic [CW-1:0] i_wr_ch,
  input  logic [1:0]    i_wr_mode,
  input  logic [PW-1:0] i_wr_level,
  output logic [NCH-1:0] o_led,
  output logic          o_frame
);

  localparam logic [PW-1:0]       PWM_MAX = '1;
  localparam logic [PRE_BITS-1:0] PRE_MAX = '1;

  logic [PW-1:0]       r_pwm_cnt;
  logic [PRE_BITS-1:0] r_pre_cnt;
  logic                r_frame;

  logic w_period_end;
  logic w_step;

  assign w_period_end = (r_pwm_cnt == PWM_MAX);
  assign w_step       = w_period_end && (r_pre_cnt == PRE_MAX);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pwm_cnt <= '0;
      r_pre_cnt <= '0;
      r_frame   <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PW'(1);
      if (w_period_end)
        r_pre_cnt <= r_pre_cnt + PRE_BITS'(1);
      // aligned with o_led: both reflect the same pwm_cnt one cycle later
      r_frame <= (r_pwm_cnt == '0);
    end
  end

  assign o_frame = r_frame;

  // One channel per index; out-of-range selects simply match no instance.
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    localparam logic [CW-1:0] CH_IDX = CW'(k);
    logic w_wr_hit;
    assign w_wr_hit = i_wr && (i_wr_ch == CH_IDX);

    breather_channel #(
      .PW(PW)
    ) u_ch (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_step       (w_step),
      .i_period_end (w_period_end),
      .i_pwm_cnt    (r_pwm_cnt),
      .i_wr         (w_wr_hit),
      .i_wr_mode    (i_wr_mode),
      .i_wr_level   (i_wr_level),
      .o_led        (o_led[k])
    );
  end

endmodule

// File: tb/tb_led_breather.sv
// ---------------------------------------------------------------------------
// tb_led_breather
//   Scoreboard bench for led_breather (NCH=3, PW=4, PRE_BITS=1). Stimulus
//   queues the expected high-time of each channel for each 16-cycle period;
//   the monitor captures each period's o_led pattern and compares it with
//   the queued entry when the period completes.
// ---------------------------------------------------------------------------
module tb_led_breather;
  import led_breather_pkg::*;

  localparam int NCH = 3;
  localparam int PW  = 4;
  localparam int PRE = 1;
  localparam int CW  = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           wr  = 1'b0;
  logic [CW-1:0]  wr_ch    = '0;
  logic [1:0]     wr_mode  = '0;
  logic [PW-1:0]  wr_level = '0;
  logic [NCH-1:0] led;
  logic           frame;

  led_breather #(.NCH(NCH), .PW(PW), .PRE_BITS(PRE)) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_wr       (wr),
    .i_wr_ch    (wr_ch),
    .i_wr_mode  (wr_mode),
    .i_wr_level (wr_level),
    .o_led      (led),
    .o_frame    (frame)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Edges since reset release: the edge numbered n leaves pwm_cnt = n mod 16.
  int ncyc = 0;
  always @(posedge clk or posedge rst)
    if (rst) ncyc <= 0;
    else     ncyc <= ncyc + 1;

  typedef struct { int per; int ch; int high; } exp_t;
  exp_t q[$];

  logic [15:0] pat [NCH];

  // Monitor: after edge n the outputs show period (n-1)/16, slot (n-1)%16.
  always @(negedge clk) begin : mon
    int pos, p;
    exp_t e;
    logic [15:0] m;
    if (!rst && ncyc >= 1) begin
      pos = (ncyc - 1) % 16;
      p   = (ncyc - 1) / 16;
      checks++;
      if (frame !== (pos == 0)) begin
        failures++;
        $display("FAIL frame ncyc=%0d got=%b need=%b", ncyc, frame, (pos == 0));
      end
      for (int c = 0; c < NCH; c++) pat[c][pos] = led[c];
      if (pos == 15) begin
        while (q.size() > 0 && q[0].per <= p) begin
          e = q.pop_front();
          checks++;
          m = (16'(1) << e.high) - 16'(1);
          if (e.per != p || pat[e.ch] !== m) begin
            failures++;
            $display("FAIL duty period=%0d ch%0d got=%b need=%b (high %0d, at period %0d)",
                     e.per, e.ch, pat[e.ch], m, e.high, p);
          end
        end
      end
    end
  end

  task automatic push(input int per, input int ch, input int high);
    exp_t e;
    e.per = per; e.ch = ch; e.high = high;
    q.push_back(e);
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] need);
    checks++;
    if (got !== need) begin
      failures++;
      $display("FAIL %s got=%0h need=%0h", name, got, need);
    end
  endtask

  task automatic wait_ncyc(input int n);
    int guard;
    guard = 0;
    while (ncyc != n && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (ncyc != n) begin
      checks++; failures++;
      $display("FAIL wait ncyc=%0d target=%0d", ncyc, n);
    end
  endtask

  // Drive a write so that it is taken on edge n.
  task automatic do_wr(input int n, input int ch, input logic [1:0] md, input int lvl);
    wait_ncyc(n - 1);
    wr = 1'b1; wr_ch = CW'(ch); wr_mode = md; wr_level = PW'(lvl);
    @(negedge clk);
    wr = 1'b0;
  endtask

  int tri_lv [19] = '{14, 15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};

  initial begin
    // ---- power-on reset ----
    #1 rst = 1'b1;
    #2;
    check("reset_led", 8'(led), 8'h0);
    check("reset_frame", 8'(frame), 8'h0);

    // Phase A: STATIC 5 on ch0, SAW 14 on ch1, TRI 14 on ch2.
    // A write on edge n shows from period n/16+1; steps fall on edges 32k,
    // and the period loaded on a step edge still gets the pre-step level.
    for (int p = 0; p <= 38; p++) begin
      push(p, 0, (p == 0) ? 0 : 5);
      push(p, 1, (p == 0) ? 0 : (14 + (p - 1) / 2) % 16);
      push(p, 2, (p == 0) ? 0 : tri_lv[(p - 1) / 2]);
    end
    @(negedge clk);
    #2 rst = 1'b0;

    do_wr(3, 0, MODE_STATIC, 5);
    do_wr(5, 1, MODE_SAW, 14);
    do_wr(7, 2, MODE_TRI, 14);

    // ---- reset mid-period with ch0 STATIC 9, others OFF ----
    do_wr(642, 0, MODE_STATIC, 9);
    do_wr(643, 1, MODE_OFF, 7);
    do_wr(644, 2, MODE_OFF, 7);
    wait_ncyc(675);
    check("phaseA_drained", 8'(q.size()), 8'h0);
    check("pre_reset_led", 8'(led), 8'h1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_led", 8'(led), 8'h0);
    check("async_reset_frame", 8'(frame), 8'h0);
    // write presented during reset must be discarded
    wr = 1'b1; wr_ch = 2'd0; wr_mode = MODE_STATIC; wr_level = 4'd9;
    @(posedge clk); @(posedge clk); #1;
    check("reset_held_led", 8'(led), 8'h0);

    // Phase B expectations (edges counted from the second release).
    for (int p = 0; p <= 3; p++)
      for (int c = 0; c < NCH; c++) push(p, c, 0);
    push(4, 0, 2);  push(4, 1, 0); push(4, 2, 0);
    push(5, 0, 10); push(5, 1, 3); push(5, 2, 0);
    push(6, 0, 10); push(6, 1, 3); push(6, 2, 0);
    push(7, 0, 10); push(7, 1, 7); push(7, 2, 1);
    push(8, 0, 10); push(8, 1, 7); push(8, 2, 1);
    push(9, 0, 10); push(9, 1, 8); push(9, 2, 2);
    @(negedge clk);
    wr = 1'b0;
    #2 rst = 1'b0;

    do_wr(50, 0, MODE_STATIC, 2);    // duty 2 from period 4
    do_wr(68, 0, MODE_STATIC, 10);   // pwm_cnt=3 inside period 4
    do_wr(70, 1, MODE_SAW, 3);
    do_wr(72, 2, MODE_TRI, 0);
    do_wr(96, 1, MODE_SAW, 7);       // lands on a step edge
    do_wr(100, 3, MODE_STATIC, 15);  // out-of-range channel

    wait_ncyc(162);
    check("phaseB_drained", 8'(q.size()), 8'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
